// File: rtl/flanger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flanger_pkg
//  Purpose  : Shared types, constants and helpers for the flanger LFO block.
//             Holds the delay width and ceiling, the sweep-direction state
//             type, and the saturating add used to derive the sweep top.
//  Revision : 1.0  initial release
// ============================================================================
package flanger_pkg;

    localparam int                  DELAY_W   = 6;
    localparam logic [DELAY_W-1:0]  DELAY_MAX = 6'd63;

    typedef enum logic [0:0] {
        LFO_RISE = 1'b0,
        LFO_FALL = 1'b1
    } lfo_state_t;

    // base + span, clamped to DELAY_MAX. The sum is formed one bit wider so
    // the overflow case is seen instead of wrapping.
    function automatic logic [DELAY_W-1:0] sat_add_delay(
        input logic [DELAY_W-1:0] base,
        input logic [DELAY_W-1:0] span
    );
        logic [DELAY_W:0] w_sum;
        w_sum = {1'b0, base} + {1'b0, span};
        return (w_sum > {1'b0, DELAY_MAX}) ? DELAY_MAX : w_sum[DELAY_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfo_phase_acc.sv
`default_nettype none
// ============================================================================
//  Module   : lfo_phase_acc
//  Purpose  : Phase accumulator for the flanger LFO. On each enabled cycle
//             the accumulator adds the rate; the carry out of the top bit is
//             registered and appears as a one-clk pulse on the following
//             cycle. A clear on an enabled cycle zeroes the phase and
//             suppresses the carry.
//  Ports    : clk       system clock
//             reset_n   asynchronous active-low reset
//             i_enable  sample strobe
//             i_clear   phase restart (honoured only with i_enable)
//             i_rate    phase increment per strobe
//             o_carry   registered carry pulse (one clk wide)
//  Revision : 1.0  initial release
// ============================================================================
module lfo_phase_acc #(
    parameter int ACC_W  = 12,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_carry
);

    logic [ACC_W-1:0] r_acc;
    logic             r_carry;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - RATE_W){1'b0}}, i_rate};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else begin
            // Carry is a pulse: it only lives for the cycle after a strobe.
            r_carry <= 1'b0;
            if (i_enable) begin
                if (i_clear) begin
                    r_acc <= '0;
                end else begin
                    r_acc   <= w_sum[ACC_W-1:0];
                    r_carry <= w_sum[ACC_W];
                end
            end
        end
    end

    assign o_carry = r_carry;

endmodule
`default_nettype wire

// File: rtl/flanger_lfo.sv
`default_nettype none
// ============================================================================
//  Module   : flanger_lfo
//  Purpose  : Triangle-wave LFO producing the 6-bit delay for the flanger.
//             The phase accumulator advances on the sample strobe; each
//             carry moves the delay one step between MIN_DELAY and
//             min(MIN_DELAY+depth, 63), turning around with no dwell.
//  Ports    : clk         system clock
//             reset_n     asynchronous active-low reset
//             clk_enable  sample strobe, one clk wide
//             rate        phase increment per strobe (0 freezes the sweep)
//             depth       sweep span above MIN_DELAY
//             sync        phase restart request (FLANGER_LFO_SYNC_EN only)
//             delay       modulated delay output
//             step        one-clk pulse in the cycle delay is updated
//             at_peak     delay at top while falling
//  Config   : `define FLANGER_LFO_SYNC_EN adds the sync input.
//  Revision : 1.0  initial release
// ============================================================================
module flanger_lfo
    import flanger_pkg::*;
#(
    parameter int MIN_DELAY = 4,
    parameter int ACC_W     = 12,
    parameter int RATE_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_enable,
    input  logic [RATE_W-1:0]  rate,
    input  logic [DELAY_W-1:0] depth,
`ifdef FLANGER_LFO_SYNC_EN
    input  logic               sync,
`endif
    output logic [DELAY_W-1:0] delay,
    output logic               step,
    output logic               at_peak
);

    localparam logic [DELAY_W-1:0] c_min_delay = DELAY_W'(MIN_DELAY);

    lfo_state_t         r_state;
    lfo_state_t         w_state_nxt;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] w_delay_nxt;
    logic [DELAY_W-1:0] r_top;
    logic [DELAY_W-1:0] w_top_now;
    logic [DELAY_W-1:0] w_inc;
    logic [DELAY_W-1:0] w_dec;
    logic               r_step;
    logic               w_step_nxt;
    logic               r_sync_pend;
    logic               w_sync_strobe;
    logic               w_carry;

`ifdef FLANGER_LFO_SYNC_EN
    assign w_sync_strobe = clk_enable & sync;
`else
    assign w_sync_strobe = 1'b0;
`endif

    assign w_top_now = sat_add_delay(c_min_delay, depth);
    assign w_inc     = r_delay + DELAY_W'(1);
    assign w_dec     = r_delay - DELAY_W'(1);

    lfo_phase_acc #(
        .ACC_W  (ACC_W),
        .RATE_W (RATE_W)
    ) u_phase_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (clk_enable),
        .i_clear  (w_sync_strobe),
        .i_rate   (rate),
        .o_carry  (w_carry)
    );

    // Depth is captured on the strobe so the step one clk later uses the
    // value that was present on the strobe cycle, like the carry itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= LFO_RISE;
            r_delay     <= c_min_delay;
            r_step      <= 1'b0;
            r_top       <= c_min_delay;
            r_sync_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_delay     <= w_delay_nxt;
            r_step      <= w_step_nxt;
            r_sync_pend <= w_sync_strobe;
            if (clk_enable) begin
                r_top <= w_top_now;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_step_nxt  = 1'b0;
        if (r_sync_pend) begin
            w_delay_nxt = c_min_delay;
            w_state_nxt = LFO_RISE;
            w_step_nxt  = 1'b1;
        end else if (w_carry) begin
            w_step_nxt = 1'b1;
            if (r_top == c_min_delay) begin
                // Zero span: pin to the floor, keep rising.
                w_delay_nxt = c_min_delay;
                w_state_nxt = LFO_RISE;
            end else if (r_delay > r_top) begin
                // Depth was cut below the current delay: clamp, head down.
                w_delay_nxt = r_top;
                w_state_nxt = LFO_FALL;
            end else if ((r_state == LFO_RISE) && (r_delay < r_top)) begin
                w_delay_nxt = w_inc;
                if (w_inc == r_top) begin
                    w_state_nxt = LFO_FALL;
                end
            end else if (r_delay > c_min_delay) begin
                // Falling, or rising but already sitting on a lowered top:
                // turn around immediately rather than dwelling.
                w_delay_nxt = w_dec;
                w_state_nxt = (w_dec == c_min_delay) ? LFO_RISE : LFO_FALL;
            end else begin
                w_state_nxt = LFO_RISE;
            end
        end
    end

    assign delay   = r_delay;
    assign step    = r_step;
    assign at_peak = (r_state == LFO_FALL) && (r_delay == r_top);

endmodule
`default_nettype wire

// File: tb/tb_flanger_lfo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flanger_lfo
//  Purpose  : Self-checking bench for flanger_lfo. A behavioural model
//             tracks phase as an integer and the sweep as a direction flag.
//  Config   : `define FLANGER_LFO_SYNC_EN to exercise the sync input.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flanger_lfo;

    localparam int MIN_D  = 4;
    localparam int ACC_W  = 12;
    localparam int RATE_W = 8;
    localparam int FULL   = 1 << ACC_W;
`ifdef FLANGER_LFO_SYNC_EN
    localparam bit SYNC_BUILD = 1'b1;
`else
    localparam bit SYNC_BUILD = 1'b0;
`endif

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b1;
    logic              clk_enable = 1'b0;
    logic [RATE_W-1:0] rate       = '0;
    logic [5:0]        depth      = '0;
`ifdef FLANGER_LFO_SYNC_EN
    logic              sync       = 1'b0;
`endif
    logic [5:0]        delay;
    logic              step;
    logic              at_peak;

    always #5 clk = ~clk;

    flanger_lfo #(
        .MIN_DELAY (MIN_D),
        .ACC_W     (ACC_W),
        .RATE_W    (RATE_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_enable (clk_enable),
        .rate       (rate),
        .depth      (depth),
`ifdef FLANGER_LFO_SYNC_EN
        .sync       (sync),
`endif
        .delay      (delay),
        .step       (step),
        .at_peak    (at_peak)
    );

    int total = 0;
    int bad   = 0;
    int steps_seen = 0;
    int obs_max = 0;
    int obs_min = 63;

    // Reference model state
    int m_phase;
    int m_delay;
    int m_top;
    bit m_rise;
    bit m_step;
    bit m_pend_carry;
    bit m_pend_sync;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_delay = MIN_D; m_top = MIN_D; m_rise = 1'b1;
        m_step = 1'b0; m_pend_carry = 1'b0; m_pend_sync = 1'b0;
    endtask

    task automatic model_step(input int top);
        if (top == MIN_D) begin
            m_delay = MIN_D; m_rise = 1'b1;
        end else if (m_delay > top) begin
            m_delay = top; m_rise = 1'b0;
        end else if (m_rise && m_delay < top) begin
            m_delay = m_delay + 1;
            if (m_delay == top) m_rise = 1'b0;
        end else if (m_delay > MIN_D) begin
            m_rise  = 1'b0;
            m_delay = m_delay - 1;
            if (m_delay == MIN_D) m_rise = 1'b1;
        end else begin
            m_rise = 1'b1;
        end
    endtask

    task automatic model_edge(input bit en, input bit sy);
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_step = 1'b0;
        if (m_pend_sync) begin
            m_delay = MIN_D; m_rise = 1'b1; m_step = 1'b1;
        end else if (m_pend_carry) begin
            m_step = 1'b1;
            model_step(m_top);
        end
        m_pend_sync  = 1'b0;
        m_pend_carry = 1'b0;
        if (en) begin
            m_top = (MIN_D + int'(depth) > 63) ? 63 : MIN_D + int'(depth);
            if (sy && SYNC_BUILD) begin
                m_phase = 0; m_pend_sync = 1'b1;
            end else begin
                m_phase = m_phase + int'(rate);
                if (m_phase >= FULL) begin
                    m_phase = m_phase - FULL; m_pend_carry = 1'b1;
                end
            end
        end
    endtask

    task automatic tick(input bit en, input bit sy);
        clk_enable = en;
`ifdef FLANGER_LFO_SYNC_EN
        sync = sy;
`endif
        @(posedge clk);
        model_edge(en, sy);
        #1;
        chk("delay",   delay,   m_delay);
        chk("step",    step,    m_step);
        chk("at_peak", at_peak, (!m_rise && m_delay == m_top));
        if (step === 1'b1) steps_seen++;
        if (int'(delay) > obs_max) obs_max = int'(delay);
        if (int'(delay) < obs_min) obs_min = int'(delay);
    endtask

    task automatic run_strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0);
            for (int j = 0; j < gap - 1; j++) tick(1'b0, 1'b0);
        end
    endtask

    // Number of strobes until a step pulse is seen; 0 if the limit expires.
    task automatic strobes_to_step(input int gap, input int limit, output int n);
        int s0;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            s0 = steps_seen;
            tick(1'b1, 1'b0);
            for (int j = 0; j < gap - 1; j++) tick(1'b0, 1'b0);
            if (steps_seen != s0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        clk_enable = 1'b0;
        #1;
        model_reset();
        chk("rst_delay",   delay,   MIN_D);
        chk("rst_step",    step,    0);
        chk("rst_at_peak", at_peak, 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int s0;
        model_reset();
        #1;

        // 1: basic triangle, rate 128, strobe every 4 clk
        do_reset();
        rate = 8'd128; depth = 6'd8;
        strobes_to_step(4, 100, n);
        chk("t1_first_step", n, 32);
        chk("t1_delay5", delay, 5);
        s0 = steps_seen;
        run_strobes(15 * 32, 4);
        chk("t1_steps", steps_seen - s0, 15);
        chk("t1_back_to_min", delay, MIN_D);

        // 2: saturated top, fast rate
        do_reset();
        rate = 8'd255; depth = 6'd63;
        strobes_to_step(2, 100, n);
        chk("t2_first_step", n, 17);
        obs_max = 0; obs_min = 63;
        run_strobes(1100, 2);
        chk("t2_reach_63", obs_max, 63);
        chk("t2_no_wrap", (obs_min >= MIN_D), 1);

        // 3: live depth reduction above new top
        do_reset();
        rate = 8'd128; depth = 6'd8;
        for (int i = 0; i < 400; i++) begin
            run_strobes(1, 4);
            if (m_delay == 11 && m_rise) break;
        end
        chk("t3_at11", delay, 11);
        depth = 6'd3;
        strobes_to_step(4, 100, n);
        chk("t3_step_gap", n, 32);
        chk("t3_clamped", delay, 7);
        chk("t3_peak", at_peak, 1);
        depth = 6'd8;
        run_strobes(64, 4);

        // 4: zero depth, then frozen rate
        do_reset();
        rate = 8'd200; depth = 6'd0;
        s0 = steps_seen;
        run_strobes(200, 4);
        chk("t4_steps_depth0", steps_seen - s0, (200 * 200) / FULL);
        rate = 8'd0;
        s0 = steps_seen;
        run_strobes(10000, 1);
        chk("t4_rate0_nostep", steps_seen - s0, 0);
        chk("t4_delay", delay, MIN_D);

        // 5: asynchronous reset mid-sweep, right on a step cycle
        do_reset();
        rate = 8'd128; depth = 6'd8;
        for (int i = 0; i < 2000; i++) begin
            tick((i % 4) == 0, 1'b0);
            if (m_step && m_delay == 7) break;
        end
        chk("t5_pre_step", step, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("t5_async_delay", delay, MIN_D);
        chk("t5_async_step",  step,  0);
        tick(1'b0, 1'b0);
        reset_n = 1'b1;
        strobes_to_step(4, 100, n);
        chk("t5_restart", n, 32);
        chk("t5_delay5", delay, 5);

        // random strobes with live rate/depth changes
        do_reset();
        rate = 8'd200; depth = 6'd10;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) rate  = 8'($urandom_range(32, 255));
            if ($urandom_range(0, 79) == 0) depth = 6'($urandom_range(0, 63));
            tick($urandom_range(0, 2) == 0, 1'b0);
        end

`ifdef FLANGER_LFO_SYNC_EN
        // 6: sync restart
        do_reset();
        rate = 8'd128; depth = 6'd8;
        for (int i = 0; i < 1000; i++) begin
            run_strobes(1, 4);
            if (m_delay == 9 && !m_rise) break;
        end
        chk("t6_at9_fall", delay, 9);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        chk("t6_sync_delay", delay, MIN_D);
        chk("t6_sync_step",  step,  1);
        tick(1'b0, 1'b1);
        chk("t6_nostrobe_step", step, 0);
        strobes_to_step(4, 100, n);
        chk("t6_acc_cleared", n, 32);
        chk("t6_delay5", delay, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
